fifo_frame_reader: RTL and testbench
====================================

Name: fifo_frame_reader

Overview:
- Drains the feature-map FIFO that sits directly upstream and presents its words as a framed valid/ready stream to the next CNN/BiLSTM compute stage.
- Hides the FIFO's one-cycle read latency (rd_en to rd_data/rd_valid) with a 2-entry skid buffer and credit-based read issue, so throughput is one word per cycle under continuous m_ready.
- Marks frame boundaries (m_last) every FRAME_LEN words and counts completed frames.

Parameters:
- DATA_WIDTH, 16, word width; must match the upstream FIFO.
- FRAME_LEN, 64, words per frame; must be at least 1.
- CNT_WIDTH, $clog2(FRAME_LEN+1), width of the beat counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  while high, new FIFO reads may be issued; a read already in flight still completes.
- fifo_empty  input  1  empty flag from the upstream FIFO.
- fifo_rd_en  output  1  read request to the FIFO; combinational.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid when fifo_rd_valid is high.
- fifo_rd_valid  input  1  high one cycle after an accepted read.
- m_data  output  DATA_WIDTH  head word of the skid buffer.
- m_valid  output  1  the skid buffer holds at least one word.
- m_ready  input  1  downstream accept.
- m_last  output  1  high together with m_valid when the head word is beat FRAME_LEN-1 of its frame.
- frame_done  output  1  one-cycle pulse, registered, in the cycle after the last beat handshakes.
- frames_out  output  16  count of completed frames; wraps modulo 2^16.
- ovf_err  output  1  sticky; a word arrived while the skid buffer was full with no pop.

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, frame_done=0, frames_out=0, ovf_err=0. Internal state also clears: skid count=0, pend=0, beat=0.
- pend: registered flag, set to (fifo_rd_en & ~fifo_empty) each cycle; marks a word that will arrive in the current cycle.
- pop = m_valid & m_ready.
- push = fifo_rd_valid. The word is written to the skid buffer tail in that same cycle.
- fifo_rd_en = enable & ~fifo_empty & ((count + pend - pop) < 2). The pop credit gives full throughput: in steady state count=1, pend=1, pop=1, and a read is still issued.
- Skid buffer:
  - 2-entry, in-order; m_data is always the oldest entry.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - Push while empty: m_valid goes high the next cycle. There is no combinational bypass from fifo_rd_data to m_data.
  - Push with count=2 and no pop: the word is dropped, ovf_err is set, count stays 2. This cannot happen under correct credit use; it exists for verification.
- m_valid and m_data stay stable while m_valid=1 and m_ready=0 (AXI-style hold).
- Beat counter:
  - Increments on pop.
  - On a pop with beat==FRAME_LEN-1: beat returns to 0, frames_out increments, and frame_done pulses the next cycle.
  - With FRAME_LEN=1, every beat is last.
- m_last = m_valid & (beat == FRAME_LEN-1).
- enable low:
  - No new reads are issued.
  - An in-flight word (pend=1) is still captured.
  - The output side keeps draining normally.
  - The beat position is kept; frames do not restart when enable is toggled.
- fifo_empty high: no reads are issued, and the output drains to m_valid=0.
- Reset mid-frame:
  - Everything clears immediately (asynchronous); buffered words are discarded and beat returns to 0.
  - A fifo_rd_valid arriving in the first cycle after reset release is still captured, since push does not depend on pend.
- Latency: a word read from a non-empty FIFO appears on m_data 2 cycles after fifo_rd_en is asserted.

Test Plan:
- Continuous flow: FIFO preloaded with 128 words, value i in word i; m_ready=1; enable=1. Required: m_data 0..127 in order with one word per cycle after a 2-cycle fill; m_last on words 63 and 127; frame_done pulses twice; frames_out=2; ovf_err=0.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly over 64 words. Required: no loss or duplication; m_data is held while stalled; fifo_rd_en never makes count+pend exceed 2; ovf_err=0.
- Enable gating: drop enable for 10 cycles mid-frame at beat 20. Required: at most 1 word arrives after the drop; output resumes at beat 21 with correct data; m_last still lands on beat 63.
- Starved FIFO: FIFO fed one word every 3 cycles. Required: m_valid pulses per word; frame boundaries stay correct; no spurious fifo_rd_en while fifo_empty=1.
- Reset mid-frame: assert rst at beat 30 with 2 words buffered. Required: all outputs reach their reset values at once; after release and refill, the next frame starts at beat 0 with m_last at beat 63 and frames_out counting from 0.
- Forced overflow: drive fifo_rd_valid directly for 3 cycles with m_ready=0 and count=2. Required: ovf_err rises and stays high; m_data still holds the original head.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// fifo_frame_reader
//
// Drains the upstream feature-map FIFO and presents its words as a framed
// valid/ready stream. The FIFO has a one-cycle read latency, so reads are
// issued against a credit (buffered words + word in flight - word leaving)
// and landed in a 2-entry skid buffer. This sustains one word per cycle under
// continuous m_ready. Every FRAME_LEN accepted words form a frame. m_last
// marks the final beat of a frame, and frames_out counts completed frames.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   enable         permits new FIFO reads (a read in flight still lands)
//   fifo_empty     upstream FIFO empty flag
//   fifo_rd_en     read request to the FIFO (combinational)
//   fifo_rd_data   FIFO read data, qualified by fifo_rd_valid
//   fifo_rd_valid  FIFO read data valid, one cycle after an accepted read
//   m_data         head word of the skid buffer
//   m_valid        skid buffer holds at least one word
//   m_ready        downstream accept
//   m_last         head word is the last beat of its frame
//   frame_done     registered one-cycle pulse after the last beat handshakes
//   frames_out     completed-frame counter, wraps modulo 2^16
//   ovf_err        sticky: a word arrived while the buffer was full, no pop
// -----------------------------------------------------------------------------
module fifo_frame_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 64,
   parameter int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  frame_done,
   output logic [15:0]           frames_out,
   output logic                  ovf_err
);

   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);

   // Skid buffer: head_q is always the oldest word, tail_q the second one.
   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  pend_q, pend_d;
   logic [CNT_WIDTH-1:0]  beat_q, beat_d;
   logic [15:0]           frames_q, frames_d;
   logic                  frame_done_q, frame_done_d;
   logic                  ovf_q, ovf_d;

   logic                  pop;
   logic                  push;
   logic [2:0]            credit;

   assign m_valid = (count_q != 2'd0);
   assign pop     = m_valid & m_ready;
   assign push    = fifo_rd_valid;

   // Occupancy the buffer will see once the in-flight word lands and the
   // current head leaves. Counting the pop lets a read go out in the steady
   // state (one buffered, one in flight, one leaving), which keeps full rate.
   // pop implies count_q >= 1, so this never underflows.
   assign credit     = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
   assign fifo_rd_en = enable & ~fifo_empty & (credit < 3'd2);

   // Next-state for the skid buffer and overflow flag.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      ovf_d   = ovf_q;
      pend_d  = fifo_rd_en & ~fifo_empty;
      unique case ({push, pop})
         2'b10: begin
            case (count_q)
               2'd0: begin
                  head_d  = fifo_rd_data;
                  count_d = 2'd1;
               end
               2'd1: begin
                  tail_d  = fifo_rd_data;
                  count_d = 2'd2;
               end
               default: begin
                  // Full with no pop: drop the word and flag it.
                  ovf_d = 1'b1;
               end
            endcase
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Count is unchanged; the new word goes behind whatever remains.
            if (count_q == 2'd1) begin
               head_d = fifo_rd_data;
            end else begin
               head_d = tail_q;
               tail_d = fifo_rd_data;
            end
         end
         default: ;
      endcase
   end

   // Beat position and frame accounting; the beat only advances on a pop, so
   // toggling enable never disturbs frame alignment.
   always_comb begin
      beat_d       = beat_q;
      frames_d     = frames_q;
      frame_done_d = 1'b0;
      if (pop) begin
         if (beat_q == LAST_BEAT) begin
            beat_d       = '0;
            frames_d     = frames_q + 16'd1;
            frame_done_d = 1'b1;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= 2'd0;
         head_q       <= '0;
         tail_q       <= '0;
         pend_q       <= 1'b0;
         beat_q       <= '0;
         frames_q     <= 16'd0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         count_q      <= count_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         pend_q       <= pend_d;
         beat_q       <= beat_d;
         frames_q     <= frames_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   assign m_data     = head_q;
   assign m_last     = m_valid & (beat_q == LAST_BEAT);
   assign frame_done = frame_done_q;
   assign frames_out = frames_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_frame_reader
//
// Directed bench for fifo_frame_reader. A behavioural upstream FIFO (one-cycle
// read latency, word i holds value i) feeds the DUT. A negedge monitor keeps a
// scoreboard of the expected word sequence, beat position, buffer occupancy
// and frame_done timing. The main process walks through the scenarios in turn:
// continuous flow, backpressure, enable gating, starved FIFO, reset mid-frame
// and forced overflow.
// -----------------------------------------------------------------------------
module tb_fifo_frame_reader;

   localparam int DW = 16;
   localparam int FL = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_valid;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          frame_done;
   logic [15:0]   frames_out;
   logic          ovf_err;

   // Upstream FIFO model
   logic [DW-1:0] fifo_mem [0:1023];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          model_valid = 1'b0;
   logic [DW-1:0] model_data = '0;

   // Direct drive of the read-data path for the overflow scenario
   logic          force_en = 1'b0;
   logic          force_valid = 1'b0;
   logic [DW-1:0] force_data = '0;

   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_rd_valid = force_en ? force_valid : model_valid;
   assign fifo_rd_data  = force_en ? force_data : model_data;

   // Scoreboard / monitor state
   int            n_checks = 0;
   int            n_errors = 0;
   int            sb_data = 0;
   int            sb_beat = 0;
   int            tb_count = 0;
   int            pop_cnt = 0;
   int            fd_cnt = 0;
   int            last_cnt = 0;
   int            mv_rise = 0;
   bit            prev_last_pop = 1'b0;
   bit            prev_stall = 1'b0;
   bit            prev_mv = 1'b0;
   logic [DW-1:0] stall_data = '0;

   fifo_frame_reader #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_valid (fifo_rd_valid),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last),
      .frame_done    (frame_done),
      .frames_out    (frames_out),
      .ovf_err       (ovf_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         model_data  <= fifo_mem[rd_ptr[9:0]];
         model_valid <= 1'b1;
         rd_ptr      <= rd_ptr + 1;
      end else begin
         model_valid <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_word();
      fifo_mem[wr_ptr[9:0]] = wr_ptr[15:0];
      wr_ptr = wr_ptr + 1;
   endtask

   // One monitor step per negedge; the upcoming posedge handshake is
   // m_valid & m_ready as seen here.
   task automatic monitor_step();
      bit pop;
      int nxt;
      if (rst) begin
         tb_count      = 0;
         sb_beat       = 0;
         sb_data       = rd_ptr;
         prev_last_pop = 1'b0;
         prev_stall    = 1'b0;
         prev_mv       = 1'b0;
      end else begin
         pop = m_valid && m_ready;
         if (fifo_empty) check_eq("rd_en_empty", fifo_rd_en, 0);
         check_eq("m_valid_occ", m_valid, tb_count != 0);
         check_eq("frame_done", frame_done, prev_last_pop);
         check_eq("m_last", m_last, m_valid && (sb_beat == FL - 1));
         if (prev_stall) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_data", m_data, stall_data);
         end
         nxt = tb_count + (fifo_rd_valid ? 1 : 0) - (pop ? 1 : 0);
         if (nxt > 2) nxt = 2;
         if (fifo_rd_en && !fifo_empty) check_eq("credit", (nxt + 1) <= 2, 1);
         if (pop) begin
            check_eq("data", m_data, sb_data[15:0]);
            prev_last_pop = (sb_beat == FL - 1);
            if (prev_last_pop) last_cnt++;
            sb_data++;
            sb_beat = (sb_beat + 1) % FL;
            pop_cnt++;
         end else begin
            prev_last_pop = 1'b0;
         end
         if (frame_done) fd_cnt++;
         if (m_valid && !prev_mv) mv_rise++;
         prev_mv    = m_valid;
         prev_stall = m_valid && !m_ready;
         stall_data = m_data;
         tb_count   = nxt;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   // Drive m_ready (steady or 1,0,0,1 pattern) until pop_cnt reaches target.
   task automatic run_until(input int target, input bit pattern, input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         @(posedge clk);
         #1;
         m_ready = pattern ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (pop_cnt >= target) done = 1'b1;
      end
      check_eq({tag, "_timeout"}, done, 1);
      m_ready = 1'b1;
   endtask

   initial begin
      int  start;
      int  rise0;
      int  arrivals;
      bit  found;

      // ---------------- reset values ----------------
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rd_en", fifo_rd_en, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_m_last", m_last, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_frames_out", frames_out, 0);
      check_eq("rst_ovf_err", ovf_err, 0);
      rst = 1'b0;

      // ---------------- continuous flow: words 0..127 ----------------
      for (int i = 0; i < 128; i++) push_word();
      m_ready = 1'b1;
      @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      check_eq("lat_rd_en", fifo_rd_en, 1);
      check_eq("lat_c0_valid", m_valid, 0);
      @(negedge clk);
      check_eq("lat_c1_valid", m_valid, 0);
      @(negedge clk);
      check_eq("lat_c2_valid", m_valid, 1);
      check_eq("lat_c2_data", m_data, 0);
      repeat (127) @(negedge clk);
      #1;
      check_eq("cont_throughput", pop_cnt, 128);
      repeat (3) @(posedge clk);
      #1;
      check_eq("cont_frames", frames_out, 2);
      check_eq("cont_fd_pulses", fd_cnt, 2);
      check_eq("cont_last_beats", last_cnt, 2);
      check_eq("cont_ovf", ovf_err, 0);
      check_eq("cont_drained", m_valid, 0);

      // ---------------- backpressure: words 128..191 ----------------
      start = pop_cnt;
      for (int i = 0; i < 64; i++) push_word();
      run_until(start + 64, 1'b1, "bp");
      repeat (3) @(posedge clk);
      #1;
      check_eq("bp_frames", frames_out, 3);
      check_eq("bp_ovf", ovf_err, 0);

      // ---------------- enable gating: words 192..255 ----------------
      start = pop_cnt;
      for (int i = 0; i < 64; i++) push_word();
      found = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         @(posedge clk);
         #1;
         if (m_valid && m_data == 16'd212) found = 1'b1;
      end
      check_eq("gate_found_beat20", found, 1);
      enable = 1'b0;
      arrivals = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_rd_valid) arrivals++;
         check_eq("gate_rd_en", fifo_rd_en, 0);
      end
      check_eq("gate_arrivals", arrivals <= 1, 1);
      @(posedge clk);
      #1 enable = 1'b1;
      run_until(start + 64, 1'b0, "gate");
      repeat (3) @(posedge clk);
      #1;
      check_eq("gate_frames", frames_out, 4);

      // ---------------- starved FIFO: words 256..319 ----------------
      start = pop_cnt;
      rise0 = mv_rise;
      for (int i = 0; i < 64; i++) begin
         push_word();
         repeat (3) @(posedge clk);
         #1;
      end
      run_until(start + 64, 1'b0, "starve");
      repeat (3) @(posedge clk);
      #1;
      check_eq("starve_pulses", mv_rise - rise0, 64);
      check_eq("starve_frames", frames_out, 5);

      // ---------------- reset mid-frame: words 320..351 ----------------
      for (int i = 0; i < 32; i++) push_word();
      found = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         @(posedge clk);
         #1;
         if (m_valid && m_data == 16'd350) begin
            m_ready = 1'b0;
            found = 1'b1;
         end
      end
      check_eq("mid_found_beat30", found, 1);
      repeat (2) @(posedge clk);
      #3;
      check_eq("mid_pre_head", m_data, 350);
      check_eq("mid_pre_frames", frames_out, 5);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", m_valid, 0);
      check_eq("mid_rst_data", m_data, 0);
      check_eq("mid_rst_last", m_last, 0);
      check_eq("mid_rst_fd", frame_done, 0);
      check_eq("mid_rst_frames", frames_out, 0);
      check_eq("mid_rst_ovf", ovf_err, 0);
      check_eq("mid_rst_rd_en", fifo_rd_en, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      start = pop_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < 64; i++) push_word();
      run_until(start + 64, 1'b0, "refill");
      repeat (3) @(posedge clk);
      #1;
      check_eq("refill_frames", frames_out, 1);
      check_eq("refill_ovf", ovf_err, 0);

      // ---------------- forced overflow: words 416,417 ----------------
      m_ready = 1'b0;
      push_word();
      push_word();
      repeat (4) @(posedge clk);
      #1;
      check_eq("ovf_pre_valid", m_valid, 1);
      check_eq("ovf_pre_head", m_data, 416);
      check_eq("ovf_pre_err", ovf_err, 0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      force_en    = 1'b1;
      force_valid = 1'b1;
      force_data  = 16'hBEEF;
      repeat (3) @(posedge clk);
      #1;
      force_valid = 1'b0;
      check_eq("ovf_err_set", ovf_err, 1);
      check_eq("ovf_head_kept", m_data, 416);
      repeat (5) @(posedge clk);
      #1;
      force_en = 1'b0;
      check_eq("ovf_err_sticky", ovf_err, 1);
      check_eq("ovf_head_still", m_data, 416);
      check_eq("ovf_valid_still", m_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
